// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master between NREQ requesters and
// sequences each granted transaction (launch, byte transfer, completion/abort).
module i2c_req_arbiter #(
    parameter int NREQ          = 2,
    parameter int ADDRESSLENGTH = 7,
    parameter int TIMEOUT       = 4096
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*ADDRESSLENGTH-1:0]   req_addr,
    input  logic [NREQ-1:0]                 req_rw,
    input  logic [NREQ*4-1:0]               req_nbytes,
    input  logic [NREQ*8-1:0]               req_wdata,
    output logic [NREQ-1:0]                 wdata_pop,
    output logic [7:0]                      rdata,
    output logic [NREQ-1:0]                 rdata_valid,
    output logic [NREQ-1:0]                 grant,
    output logic [NREQ-1:0]                 done,
    output logic [NREQ-1:0]                 err,
    output logic                            m_start,
    output logic                            m_abort,
    output logic [ADDRESSLENGTH-1:0]        m_addr,
    output logic                            m_rw,
    output logic [3:0]                      m_nbytes,
    output logic [7:0]                      m_txdata,
    input  logic                            m_tx_req,
    input  logic                            m_rx_valid,
    input  logic [7:0]                      m_rxdata,
    input  logic                            m_done,
    input  logic                            m_nack
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, XFER, FINISH} state_t;

    state_t                     state_reg, state_next;
    logic [IW-1:0]              rr_reg;
    logic [IW-1:0]              gidx_reg;
    logic [NREQ-1:0]            grant_reg;
    logic [ADDRESSLENGTH-1:0]   addr_reg;
    logic                       rw_reg;
    logic [3:0]                 nbytes_reg;
    logic [3:0]                 cnt_reg;
    logic [TW-1:0]              tmo_reg;
    logic                       errf_reg;
    logic [7:0]                 rdata_reg;
    logic [NREQ-1:0]            rvalid_reg;
    logic [NREQ-1:0]            pop_reg;

    logic                       win_found;
    logic [IW-1:0]              win_idx;
    logic [NREQ-1:0]            win_onehot;
    logic [ADDRESSLENGTH-1:0]   win_addr;
    logic                       win_rw;
    logic [3:0]                 win_nbytes;

    logic                       activity;
    logic                       tmo_hit;
    logic [4:0]                 cnt_sum;
    logic [3:0]                 cnt_next;

    // First set request at or above the rr pointer, wrapping past NREQ-1.
    always_comb begin
        int idx;
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        win_addr   = '0;
        win_rw     = 1'b0;
        win_nbytes = '0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_reg) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req[idx]) begin
                win_found       = 1'b1;
                win_idx         = IW'(idx);
                win_onehot      = '0;
                win_onehot[idx] = 1'b1;
                win_addr        = req_addr[idx*ADDRESSLENGTH +: ADDRESSLENGTH];
                win_rw          = req_rw[idx];
                win_nbytes      = req_nbytes[idx*4 +: 4];
            end
        end
    end

    assign activity = m_tx_req | m_rx_valid | m_done | m_nack;
    assign tmo_hit  = (state_reg == XFER) && !activity && (tmo_reg == TMO_LAST);
    assign cnt_sum  = {1'b0, cnt_reg} + {4'b0, m_tx_req} + {4'b0, m_rx_valid};
    assign cnt_next = cnt_sum[4] ? 4'hF : cnt_sum[3:0];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found) state_next = (win_nbytes == 4'd0) ? FINISH : LAUNCH;
            LAUNCH:  state_next = XFER;
            XFER:    if (m_nack || m_done || tmo_hit) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_reg     <= '0;
            gidx_reg   <= '0;
            grant_reg  <= '0;
            addr_reg   <= '0;
            rw_reg     <= 1'b0;
            nbytes_reg <= '0;
            cnt_reg    <= '0;
            tmo_reg    <= '0;
            errf_reg   <= 1'b0;
            rdata_reg  <= '0;
            rvalid_reg <= '0;
            pop_reg    <= '0;
        end else begin
            pop_reg    <= '0;
            rvalid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        gidx_reg   <= win_idx;
                        grant_reg  <= win_onehot;
                        addr_reg   <= win_addr;
                        rw_reg     <= win_rw;
                        nbytes_reg <= win_nbytes;
                        cnt_reg    <= '0;
                        tmo_reg    <= '0;
                        errf_reg   <= (win_nbytes == 4'd0);
                    end
                end
                XFER: begin
                    cnt_reg <= cnt_next;
                    if (m_tx_req) begin
                        pop_reg <= grant_reg;
                    end
                    if (m_rx_valid) begin
                        rdata_reg  <= m_rxdata;
                        rvalid_reg <= grant_reg;
                    end
                    tmo_reg <= activity ? '0 : tmo_reg + 1'b1;
                    // cnt_next already includes a byte arriving alongside m_done.
                    if (m_nack || tmo_hit || (m_done && (cnt_next != nbytes_reg))) begin
                        errf_reg <= 1'b1;
                    end
                end
                FINISH: begin
                    grant_reg <= '0;
                    rr_reg    <= (gidx_reg == IDX_LAST) ? '0 : gidx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_start = (state_reg == LAUNCH);
        m_abort = tmo_hit;
        done    = (state_reg == FINISH) ? grant_reg : '0;
        err     = ((state_reg == FINISH) && errf_reg) ? grant_reg : '0;
    end

    logic [7:0] tx_terms [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_txmux
            assign tx_terms[gi] = grant_reg[gi] ? req_wdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        m_txdata = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            m_txdata = m_txdata | tx_terms[i];
        end
    end

    assign grant       = grant_reg;
    assign wdata_pop   = pop_reg;
    assign rdata_valid = rvalid_reg;
    assign rdata       = rdata_reg;
    assign m_addr      = addr_reg;
    assign m_rw        = rw_reg;
    assign m_nbytes    = nbytes_reg;

endmodule
